// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-resource arbiter.
interface rr_req_arbiter_if;
  logic [5:0] req;
  logic       done;
  logic       rr_en;
  logic [5:0] gnt;
  logic [2:0] gnt_id;
  logic       v;
  logic       timeout;

  // Requester side: raises requests, releases, selects the arbitration mode.
  modport master (
    output req, done, rr_en,
    input  gnt, gnt_id, v, timeout
  );

  // Arbiter side.
  modport slave (
    input  req, done, rr_en,
    output gnt, gnt_id, v, timeout
  );
endinterface

// File: rtl/rr_req_arbiter.sv
// Six-way request arbiter with fixed-priority or round-robin selection.
// A grant is held until done, withdrawal of the request, or a hold timeout.
// Every release is followed by exactly one dead cycle in which the next
// winner is chosen.
module rr_req_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  rr_req_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state, state_d;
  logic [2:0]       ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [5:0]       gnt_r, gnt_d;
  logic [2:0]       gnt_id_r, gnt_id_d;
  logic             v_r, v_d;
  logic             timeout_r, timeout_d;

  logic [2:0]       search_start;
  logic             win_found;
  logic [2:0]       win_id;
  logic             still_req;

  // Descending circular search from the start index; first set request wins.
  always_comb begin
    search_start = bus.rr_en ? ptr : 3'd5;
    win_found    = 1'b0;
    win_id       = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      int unsigned idx;
      logic [2:0]  idx3;
      idx  = (32'(search_start) + 32'd6 - i) % 32'd6;
      idx3 = 3'(idx);
      if (!win_found && bus.req[idx3]) begin
        win_found = 1'b1;
        win_id    = idx3;
      end
    end
  end

  // The granted requester is still asking iff its request line is in the grant mask.
  always_comb begin
    still_req = |(bus.req & gnt_r);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    gnt_d     = gnt_r;
    gnt_id_d  = gnt_id_r;
    v_d       = v_r;
    timeout_d = 1'b0;

    case (state)
      IDLE, GAP: begin
        gnt_d   = '0;
        v_d     = 1'b0;
        state_d = IDLE;
        if (win_found) begin
          state_d  = GRANT;
          gnt_d    = 6'b000001 << win_id;
          gnt_id_d = win_id;
          v_d      = 1'b1;
          cnt_d    = '0;
          if (bus.rr_en) begin
            ptr_d = (win_id == 3'd0) ? 3'd5 : win_id - 3'd1;
          end
        end
      end

      GRANT: begin
        if (bus.done || !still_req) begin
          state_d = GAP;
          gnt_d   = '0;
          v_d     = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_d   = GAP;
          gnt_d     = '0;
          v_d       = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        v_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      ptr       <= 3'd5;
      cnt       <= '0;
      gnt_r     <= '0;
      gnt_id_r  <= '0;
      v_r       <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      gnt_r     <= gnt_d;
      gnt_id_r  <= gnt_id_d;
      v_r       <= v_d;
      timeout_r <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.gnt_id  = gnt_id_r;
  assign bus.v       = v_r;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: reset, fixed priority, round-robin,
// timeout, withdrawal without preemption, and coincident done/timeout.
module tb_rr_req_arbiter;

  logic clk;
  logic rst_b;
  int   n_cmp;
  int   n_err;

  rr_req_arbiter_if bus ();

  rr_req_arbiter #(
    .HOLD_MAX (8),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_gnt, input logic [2:0] e_id,
                         input logic e_v, input logic e_to);
    chk({tag, ".gnt"},     32'(bus.gnt),     32'(e_gnt));
    chk({tag, ".gnt_id"},  32'(bus.gnt_id),  32'(e_id));
    chk({tag, ".v"},       32'(bus.v),       32'(e_v));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(e_to));
  endtask

  initial begin
    logic [2:0] rr_ids [5];
    n_cmp = 0;
    n_err = 0;
    rr_ids[0] = 3'd5; rr_ids[1] = 3'd2; rr_ids[2] = 3'd0;
    rr_ids[3] = 3'd5; rr_ids[4] = 3'd2;

    // Reset with every request raised.
    rst_b      = 1'b0;
    bus.req    = 6'b111111;
    bus.done   = 1'b0;
    bus.rr_en  = 1'b0;
    #12;
    chk_out("reset", 6'b000000, 3'd0, 1'b0, 1'b0);
    tick();
    chk_out("reset_held", 6'b000000, 3'd0, 1'b0, 1'b0);

    // Fixed priority: 4 beats 3 and 1 every time.
    bus.req = 6'b011010;
    rst_b   = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk_out("fixed_grant", 6'b010000, 3'd4, 1'b1, 1'b0);
      tick();
      chk_out("fixed_hold", 6'b010000, 3'd4, 1'b1, 1'b0);
      bus.done = 1'b1;
      tick();
      chk_out("fixed_gap", 6'b000000, 3'd4, 1'b0, 1'b0);
      bus.done = 1'b0;
    end
    bus.req = 6'b000000;
    tick();
    chk_out("fixed_idle", 6'b000000, 3'd4, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant.
    bus.req = 6'b000100;
    tick();
    chk_out("pre_rst_grant", 6'b000100, 3'd2, 1'b1, 1'b0);
    #3;
    rst_b = 1'b0;
    #1;
    chk_out("async_rst", 6'b000000, 3'd0, 1'b0, 1'b0);
    tick();

    // Round-robin from reset: 5, 2, 0, 5, 2.
    bus.req   = 6'b100101;
    bus.rr_en = 1'b1;
    rst_b     = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk_out("rr_grant", 6'b000001 << rr_ids[g], rr_ids[g], 1'b1, 1'b0);
      bus.done = 1'b1;
      tick();
      chk_out("rr_gap", 6'b000000, rr_ids[g], 1'b0, 1'b0);
      bus.done = 1'b0;
    end

    // Withdrawal: 2 granted, 5 raised but must not preempt.
    bus.rr_en = 1'b0;
    bus.req   = 6'b000100;
    tick();
    chk_out("wd_grant2", 6'b000100, 3'd2, 1'b1, 1'b0);
    bus.req = 6'b100100;
    tick();
    chk_out("no_preempt1", 6'b000100, 3'd2, 1'b1, 1'b0);
    tick();
    chk_out("no_preempt2", 6'b000100, 3'd2, 1'b1, 1'b0);
    bus.req = 6'b100000;
    tick();
    chk_out("wd_release", 6'b000000, 3'd2, 1'b0, 1'b0);
    tick();
    chk_out("wd_grant5", 6'b100000, 3'd5, 1'b1, 1'b0);
    bus.req = 6'b000000;
    tick();
    chk_out("wd5_release", 6'b000000, 3'd5, 1'b0, 1'b0);
    tick();
    chk_out("idle_id_hold", 6'b000000, 3'd5, 1'b0, 1'b0);

    // done while nothing is granted has no effect.
    bus.done = 1'b1;
    tick();
    chk_out("done_idle", 6'b000000, 3'd5, 1'b0, 1'b0);
    bus.done = 1'b0;

    // Timeout: 8 granted cycles, one timeout pulse, then regrant.
    bus.req = 6'b000001;
    tick();
    chk_out("to_grant", 6'b000001, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out("to_hold", 6'b000001, 3'd0, 1'b1, 1'b0);
    end
    tick();
    chk_out("to_pulse", 6'b000000, 3'd0, 1'b0, 1'b1);
    tick();
    chk_out("to_regrant", 6'b000001, 3'd0, 1'b1, 1'b0);

    // done on the last hold cycle suppresses the timeout pulse.
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out("sim_hold", 6'b000001, 3'd0, 1'b1, 1'b0);
    end
    bus.done = 1'b1;
    tick();
    chk_out("sim_done_wins", 6'b000000, 3'd0, 1'b0, 1'b0);
    bus.done = 1'b0;
    tick();
    chk_out("sim_regrant", 6'b000001, 3'd0, 1'b1, 1'b0);
    bus.req = 6'b000000;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
